alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: TAG_W, 4, command tag width; ERR_CNT_W, 8, error counter width.
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic rising-edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid in 1, cmd_ready out 1, cmd_a in 16, cmd_b in 16, cmd_op in 2 (00 add, 01 sub, 10 mul, 11 div), cmd_cin in 1, cmd_bin in 1, cmd_tag in TAG_W: command channel.
REQ-005 d_a out 16, d_b out 16, op_code out 2, cin out 1, bin out 1, en_a out 1, en_b out 1, en_result out 1: drive the downstream computing unit.
REQ-006 alu_result in 32, alu_remainder in 16, alu_cout in 1, alu_bout in 1, alu_overflow in 1, alu_error in 1: registered outputs of the computing unit.
REQ-007 rsp_valid out 1, rsp_ready in 1, rsp_result out 32, rsp_remainder out 16, rsp_flags out 4 ({error, overflow, bout, cout}), rsp_tag out TAG_W: response channel.
REQ-008 cmd_count out 16, err_count out ERR_CNT_W: statistics.

Function
REQ-009 FSM SHALL have states IDLE, LOAD, EXEC, CAPT, RESP; one state per cycle except IDLE and RESP.
REQ-010 cmd_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-011 IDLE: on cmd_valid&cmd_ready, register cmd_a->d_a, cmd_b->d_b, cmd_op->op_code, cmd_cin->cin, cmd_bin->bin, cmd_tag->internal tag; go to LOAD.
REQ-012 LOAD: en_a=en_b=1 for exactly this cycle; next EXEC.
REQ-013 EXEC: en_result=1 for exactly this cycle; next CAPT.
REQ-014 CAPT: latch alu_result, alu_remainder, flags, tag into rsp_* registers; next RESP.
REQ-015 RESP: rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready; then IDLE.
REQ-016 en_a, en_b, en_result SHALL be 0 in every state other than as in REQ-012/013.
REQ-017 d_a, d_b, op_code, cin, bin SHALL hold from acceptance until the next acceptance.
REQ-018 Latency: command accepted at edge N -> rsp_valid first high in the cycle after edge N+3; minimum issue interval 5 cycles with rsp_ready held 1.
REQ-019 cmd_valid in non-IDLE states SHALL be ignored; no command buffered.
REQ-020 cmd_count SHALL increment by 1 on each response handshake, wrapping 0xFFFF->0.
REQ-021 err_count SHALL increment in CAPT when alu_error=1, saturating at all-ones.
REQ-022 rsp_* SHALL be registered; rsp_* values outside RESP retain last response.

Reset
REQ-023 rstn=0 at a clock edge SHALL force state IDLE and zero every output register: d_a, d_b, op_code, cin, bin, en_*, rsp_*, cmd_count, err_count.
REQ-024 Reset in any state mid-operation SHALL abort the command with no response issued; cmd_ready=1 in the first cycle after reset release.
REQ-025 Reset SHALL take priority over simultaneous cmd/rsp handshakes.

Verification
REQ-026 add: cmd_a=0x7FFF, cmd_b=0x0001, cin=0, tag=3 -> rsp_result=0x00008000, rsp_flags=0100, rsp_tag=3, rsp_valid 4 cycles after accept edge.
REQ-027 div by zero: cmd_a=0x1234, cmd_b=0x0000, op=11 -> rsp_result=0, rsp_remainder=0, rsp_flags=1000, err_count 0->1.
REQ-028 mul: 0x0100*0x0100 -> rsp_result=0x00010000, overflow=1; div 100/7 -> result=14, remainder=2, flags=0000.
REQ-029 backpressure: rsp_ready=0 for 10 cycles in RESP with cmd_valid=1 -> rsp_* stable, cmd_ready=0, no en_* pulses; on rsp_ready=1 handshake, cmd_count+1, IDLE next.
REQ-030 reset in EXEC -> next cycle all outputs 0, rsp_valid never asserts for aborted command; err_count saturation: 256 div-by-zero commands -> err_count=0xFF.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Accepts one arithmetic command at a time, steps an external computing unit
// through load/execute, captures its registered outputs and presents them on
// a ready/valid response channel. Also keeps handshake and error statistics.

module alu_cmd_sequencer #(
   parameter int TAG_W     = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rstn,

   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [15:0]          cmd_a,
   input  logic [15:0]          cmd_b,
   input  logic [1:0]           cmd_op,
   input  logic                 cmd_cin,
   input  logic                 cmd_bin,
   input  logic [TAG_W-1:0]     cmd_tag,

   output logic [15:0]          d_a,
   output logic [15:0]          d_b,
   output logic [1:0]           op_code,
   output logic                 cin,
   output logic                 bin,
   output logic                 en_a,
   output logic                 en_b,
   output logic                 en_result,

   input  logic [31:0]          alu_result,
   input  logic [15:0]          alu_remainder,
   input  logic                 alu_cout,
   input  logic                 alu_bout,
   input  logic                 alu_overflow,
   input  logic                 alu_error,

   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_result,
   output logic [15:0]          rsp_remainder,
   output logic [3:0]           rsp_flags,
   output logic [TAG_W-1:0]     rsp_tag,

   output logic [15:0]          cmd_count,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] EXEC = 3'd2;
   localparam logic [2:0] CAPT = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [TAG_W-1:0] tag;
   logic             accept;
   logic             rsp_fire;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;

   // Sequence: wait for a command, then one cycle each for load/exec/capture,
   // then hold the response until the consumer takes it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_valid) state_next = LOAD;
         LOAD:    state_next = EXEC;
         EXEC:    state_next = CAPT;
         CAPT:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset aborts whatever command is in flight.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // Operand registers feeding the computing unit, held until the next accept.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         d_a     <= '0;
         d_b     <= '0;
         op_code <= '0;
         cin     <= 1'b0;
         bin     <= 1'b0;
         tag     <= '0;
      end else if (accept) begin
         d_a     <= cmd_a;
         d_b     <= cmd_b;
         op_code <= cmd_op;
         cin     <= cmd_cin;
         bin     <= cmd_bin;
         tag     <= cmd_tag;
      end
   end

   // Registered strobes: operand enables high during LOAD, result enable during EXEC.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         en_a      <= 1'b0;
         en_b      <= 1'b0;
         en_result <= 1'b0;
      end else begin
         en_a      <= accept;
         en_b      <= accept;
         en_result <= (state == LOAD);
      end
   end

   // Response registers: captured once in CAPT, kept after the handshake.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rsp_valid     <= 1'b0;
         rsp_result    <= '0;
         rsp_remainder <= '0;
         rsp_flags     <= '0;
         rsp_tag       <= '0;
      end else if (state == CAPT) begin
         rsp_valid     <= 1'b1;
         rsp_result    <= alu_result;
         rsp_remainder <= alu_remainder;
         rsp_flags     <= {alu_error, alu_overflow, alu_bout, alu_cout};
         rsp_tag       <= tag;
      end else if (rsp_fire) begin
         rsp_valid     <= 1'b0;
      end
   end

   // Statistics: wrapping handshake counter and saturating error counter.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cmd_count <= '0;
         err_count <= '0;
      end else begin
         if (rsp_fire)
            cmd_count <= cmd_count + 16'd1;
         if ((state == CAPT) && alu_error && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Drives the sequencer with directed and random commands, stands in for the
// computing unit, and compares responses and counters against a behavioural model.

module tb_alu_cmd_sequencer;

   localparam int TAG_W     = 4;
   localparam int ERR_CNT_W = 8;

   typedef struct packed {
      logic [31:0] result;
      logic [15:0] rem;
      logic [3:0]  flags;
   } rsp_t;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [15:0]          cmd_a;
   logic [15:0]          cmd_b;
   logic [1:0]           cmd_op;
   logic                 cmd_cin;
   logic                 cmd_bin;
   logic [TAG_W-1:0]     cmd_tag;
   logic [15:0]          d_a;
   logic [15:0]          d_b;
   logic [1:0]           op_code;
   logic                 cin;
   logic                 bin;
   logic                 en_a;
   logic                 en_b;
   logic                 en_result;
   logic [31:0]          alu_result = '0;
   logic [15:0]          alu_remainder = '0;
   logic                 alu_cout = 1'b0;
   logic                 alu_bout = 1'b0;
   logic                 alu_overflow = 1'b0;
   logic                 alu_error = 1'b0;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [31:0]          rsp_result;
   logic [15:0]          rsp_remainder;
   logic [3:0]           rsp_flags;
   logic [TAG_W-1:0]     rsp_tag;
   logic [15:0]          cmd_count;
   logic [ERR_CNT_W-1:0] err_count;

   logic [15:0]          alu_a = '0;
   logic [15:0]          alu_b = '0;

   int tests = 0;
   int fails = 0;
   int exp_cmd = 0;
   int exp_err = 0;

   alu_cmd_sequencer #(.TAG_W(TAG_W), .ERR_CNT_W(ERR_CNT_W)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_bin(cmd_bin), .cmd_tag(cmd_tag),
      .d_a(d_a), .d_b(d_b), .op_code(op_code), .cin(cin), .bin(bin),
      .en_a(en_a), .en_b(en_b), .en_result(en_result),
      .alu_result(alu_result), .alu_remainder(alu_remainder), .alu_cout(alu_cout),
      .alu_bout(alu_bout), .alu_overflow(alu_overflow), .alu_error(alu_error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_remainder(rsp_remainder), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .cmd_count(cmd_count), .err_count(err_count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Arithmetic reference: flags are {error, overflow, borrow-out, carry-out}.
   function automatic rsp_t model_alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] op, input logic ci, input logic bi);
      rsp_t r;
      logic [16:0] s;
      logic [31:0] p;
      r = '0;
      case (op)
         2'b00: begin
            s = {1'b0, a} + {1'b0, b} + {16'b0, ci};
            r.result = {16'b0, s[15:0]};
            r.flags[0] = s[16];
            r.flags[2] = (a[15] == b[15]) && (s[15] != a[15]);
         end
         2'b01: begin
            s = {1'b0, a} - {1'b0, b} - {16'b0, bi};
            r.result = {16'b0, s[15:0]};
            r.flags[1] = s[16];
            r.flags[2] = (a[15] != b[15]) && (s[15] != a[15]);
         end
         2'b10: begin
            p = {16'b0, a} * {16'b0, b};
            r.result = p;
            r.flags[2] = |p[31:16];
         end
         default: begin
            if (b == 16'd0) begin
               r.flags[3] = 1'b1;
            end else begin
               r.result = {16'b0, a / b};
               r.rem    = a % b;
            end
         end
      endcase
      return r;
   endfunction

   // Stand-in computing unit: latches operands on en_a/en_b, registers the result on en_result.
   always @(posedge clk) begin
      if (en_a) alu_a <= d_a;
      if (en_b) alu_b <= d_b;
      if (en_result)
         {alu_result, alu_remainder, alu_error, alu_overflow, alu_bout, alu_cout}
            <= model_alu(alu_a, alu_b, op_code, cin, bin);
   end

   // Record a completed handshake in the expected statistics.
   function automatic void note_done(input logic [3:0] flags);
      exp_cmd = (exp_cmd + 1) % 65536;
      if (flags[3] && exp_err < 255) exp_err = exp_err + 1;
   endfunction

   // Present a command from a negedge and return at the negedge after the accept edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic ci, input logic bi, input logic [TAG_W-1:0] tag,
                        output bit ok);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = ci; cmd_bin = bi; cmd_tag = tag;
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) ok = 1'b1;
         @(negedge clk);
         if (ok) break;
      end
      cmd_valid = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid; lat counts negedges since the accept edge.
   task automatic wait_rsp(output bit ok, output int lat);
      ok  = 1'b0;
      lat = 1;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_cin = 1'b0; cmd_bin = 1'b0; cmd_tag = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({d_a, d_b, op_code, cin, bin} !== 36'd0) begin
         fails++; $display("[TB] FAIL reset_operands: got %h expected 0", {d_a, d_b, op_code, cin, bin});
      end
      tests++;
      if ({en_a, en_b, en_result, rsp_valid} !== 4'b0000) begin
         fails++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {en_a, en_b, en_result, rsp_valid});
      end
      tests++;
      if ({rsp_result, rsp_remainder, rsp_flags, rsp_tag, cmd_count, err_count} !== '0) begin
         fails++; $display("[TB] FAIL reset_rsp_stats: got %h expected 0",
                           {rsp_result, rsp_remainder, rsp_flags, rsp_tag, cmd_count, err_count});
      end
      rstn = 1'b1;
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_add();
      bit ok;
      int lat;
      rsp_ready = 1'b1;
      issue(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, 4'd3, ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL add_accept: got timeout expected accept"); end
      tests++;
      if ({en_a, en_b, en_result, cmd_ready} !== 4'b1100) begin
         fails++; $display("[TB] FAIL load_strobes: got %b expected 1100", {en_a, en_b, en_result, cmd_ready});
      end
      @(negedge clk);
      tests++;
      if ({en_a, en_b, en_result} !== 3'b001) begin
         fails++; $display("[TB] FAIL exec_strobe: got %b expected 001", {en_a, en_b, en_result});
      end
      wait_rsp(ok, lat);
      lat = lat + 1;
      tests++;
      if (!ok || lat != 4) begin
         fails++; $display("[TB] FAIL add_latency: got %0d (ok=%0d) expected 4", lat, ok);
      end
      tests++;
      if ({rsp_result, rsp_flags, rsp_tag} !== {32'h0000_8000, 4'b0100, 4'd3}) begin
         fails++; $display("[TB] FAIL add_rsp: got %h/%b/%0d expected 00008000/0100/3",
                           rsp_result, rsp_flags, rsp_tag);
      end
      @(negedge clk);
      note_done(4'b0100);
      tests++;
      if (cmd_count !== 16'(exp_cmd) || rsp_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL add_count: got %0d/%b expected %0d/0", cmd_count, rsp_valid, exp_cmd);
      end
   endtask

   task automatic test_div_zero();
      bit ok;
      int lat;
      issue(16'h1234, 16'h0000, 2'b11, 1'b0, 1'b0, 4'd5, ok);
      wait_rsp(ok, lat);
      tests++;
      if (!ok || {rsp_result, rsp_remainder, rsp_flags} !== {32'd0, 16'd0, 4'b1000}) begin
         fails++; $display("[TB] FAIL div0_rsp: got %h/%h/%b expected 0/0/1000",
                           rsp_result, rsp_remainder, rsp_flags);
      end
      @(negedge clk);
      note_done(4'b1000);
      tests++;
      if (err_count !== 8'd1) begin
         fails++; $display("[TB] FAIL div0_errcount: got %0d expected 1", err_count);
      end
   endtask

   task automatic test_mul_div();
      bit ok;
      int lat;
      issue(16'h0100, 16'h0100, 2'b10, 1'b0, 1'b0, 4'd7, ok);
      wait_rsp(ok, lat);
      tests++;
      if (!ok || rsp_result !== 32'h0001_0000 || rsp_flags[2] !== 1'b1) begin
         fails++; $display("[TB] FAIL mul_rsp: got %h/%b expected 00010000/overflow", rsp_result, rsp_flags);
      end
      @(negedge clk);
      note_done(4'b0100);
      issue(16'd100, 16'd7, 2'b11, 1'b0, 1'b0, 4'd8, ok);
      wait_rsp(ok, lat);
      tests++;
      if (!ok || {rsp_result, rsp_remainder, rsp_flags} !== {32'd14, 16'd2, 4'b0000}) begin
         fails++; $display("[TB] FAIL div_rsp: got %0d/%0d/%b expected 14/2/0000",
                           rsp_result, rsp_remainder, rsp_flags);
      end
      @(negedge clk);
      note_done(4'b0000);
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      bit bad;
      logic [67:0] snap;
      rsp_ready = 1'b0;
      issue(16'h4321, 16'h1111, 2'b01, 1'b0, 1'b1, 4'd9, ok);
      wait_rsp(ok, lat);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL bp_valid: got timeout expected rsp_valid"); end
      snap = {rsp_result, rsp_remainder, rsp_flags, rsp_tag};
      cmd_a = 16'hAAAA; cmd_b = 16'h5555; cmd_op = 2'b10; cmd_tag = 4'd1; cmd_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({rsp_result, rsp_remainder, rsp_flags, rsp_tag} !== snap || rsp_valid !== 1'b1 ||
             cmd_ready !== 1'b0 || {en_a, en_b, en_result} !== 3'b000)
            bad = 1'b1;
      end
      tests++;
      if (bad) begin fails++; $display("[TB] FAIL bp_hold: got change during stall expected stable"); end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      note_done(snap[7:4]);
      tests++;
      if (cmd_count !== 16'(exp_cmd) || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL bp_release: got %0d/%b/%b expected %0d/1/0",
                           cmd_count, cmd_ready, rsp_valid, exp_cmd);
      end
      tests++;
      if ({rsp_result, rsp_remainder, rsp_flags, rsp_tag} !== snap || d_a !== 16'h4321) begin
         fails++; $display("[TB] FAIL bp_retain: got %h/%h expected %h/4321",
                           {rsp_result, rsp_remainder, rsp_flags, rsp_tag}, d_a, snap);
      end
   endtask

   task automatic test_back_to_back();
      int accepts[$];
      bit bad;
      rsp_ready = 1'b1;
      cmd_a = 16'd1; cmd_b = 16'd2; cmd_op = 2'b00; cmd_cin = 1'b0; cmd_bin = 1'b0; cmd_tag = 4'd2;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) accepts.push_back(i);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      bad = (accepts.size() != 4);
      for (int i = 1; i < accepts.size(); i++)
         if (accepts[i] - accepts[i-1] != 5) bad = 1'b1;
      tests++;
      if (bad) begin
         fails++; $display("[TB] FAIL b2b_interval: got %0d accepts expected 4 spaced by 5", accepts.size());
      end
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      for (int i = 0; i < 4; i++) note_done(4'b0000);
      tests++;
      if (cmd_count !== 16'(exp_cmd)) begin
         fails++; $display("[TB] FAIL b2b_count: got %0d expected %0d", cmd_count, exp_cmd);
      end
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      logic [15:0] a, b;
      logic [1:0] op;
      logic ci, bi;
      logic [TAG_W-1:0] tag;
      rsp_t e;
      for (int n = 0; n < 40; n++) begin
         a   = 16'($urandom);
         b   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         op  = 2'($urandom_range(0, 3));
         ci  = 1'($urandom);
         bi  = 1'($urandom);
         tag = TAG_W'($urandom);
         e   = model_alu(a, b, op, ci, bi);
         rsp_ready = 1'b0;
         issue(a, b, op, ci, bi, tag, ok);
         wait_rsp(ok, lat);
         tests++;
         if (!ok || lat != 4) begin
            fails++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected 4", n, lat);
         end
         tests++;
         if ({rsp_result, rsp_remainder, rsp_flags, rsp_tag} !== {e.result, e.rem, e.flags, tag}) begin
            fails++; $display("[TB] FAIL rnd_rsp[%0d]: got %h/%h/%b/%0d expected %h/%h/%b/%0d", n,
                              rsp_result, rsp_remainder, rsp_flags, rsp_tag, e.result, e.rem, e.flags, tag);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         rsp_ready = 1'b1;
         @(negedge clk);
         note_done(e.flags);
         tests++;
         if (cmd_count !== 16'(exp_cmd) || err_count !== 8'(exp_err) ||
             {d_a, d_b, op_code} !== {a, b, op}) begin
            fails++; $display("[TB] FAIL rnd_state[%0d]: got %0d/%0d/%h expected %0d/%0d/%h", n,
                              cmd_count, err_count, {d_a, d_b, op_code}, exp_cmd, exp_err, {a, b, op});
         end
      end
   endtask

   task automatic test_reset_exec();
      bit ok;
      int lat;
      bit seen;
      rsp_ready = 1'b1;
      issue(16'h0003, 16'h0004, 2'b00, 1'b0, 1'b0, 4'd4, ok);
      wait_rsp(ok, lat);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_cmd = 0; exp_err = 0;
      tests++;
      if (cmd_count !== 16'd0 || rsp_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_priority: got %0d/%b expected 0/0", cmd_count, rsp_valid);
      end
      @(negedge clk);
      issue(16'hBEEF, 16'h0000, 2'b11, 1'b1, 1'b1, 4'd6, ok);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      tests++;
      if ({d_a, d_b, op_code, cin, bin, en_a, en_b, en_result, rsp_valid} !== 40'd0 ||
          {rsp_result, rsp_remainder, rsp_flags, rsp_tag, cmd_count, err_count} !== '0) begin
         fails++; $display("[TB] FAIL reset_exec_zero: got %h expected 0",
                           {d_a, d_b, op_code, cin, bin, en_a, en_b, en_result, rsp_valid});
      end
      rstn = 1'b1;
      @(negedge clk);
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++; $display("[TB] FAIL reset_exec_ready: got %b expected 1", cmd_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      tests++;
      if (seen || err_count !== 8'd0) begin
         fails++; $display("[TB] FAIL reset_exec_abort: got valid=%b err=%0d expected 0/0", seen, err_count);
      end
   endtask

   task automatic test_err_saturation();
      bit ok;
      int lat;
      rsp_ready = 1'b1;
      for (int n = 0; n < 260; n++) begin
         issue(16'($urandom), 16'h0000, 2'b11, 1'b0, 1'b0, TAG_W'(n), ok);
         wait_rsp(ok, lat);
         if (!ok) begin
            tests++; fails++;
            $display("[TB] FAIL sat_timeout[%0d]: got timeout expected response", n);
            break;
         end
         @(negedge clk);
         note_done(4'b1000);
         if (n == 254 || n == 255 || n == 259) begin
            tests++;
            if (err_count !== 8'(exp_err)) begin
               fails++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", n, err_count, exp_err);
            end
         end
      end
      tests++;
      if (err_count !== 8'hFF || cmd_count !== 16'(exp_cmd)) begin
         fails++; $display("[TB] FAIL sat_final: got %h/%0d expected FF/%0d", err_count, cmd_count, exp_cmd);
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_add();
      test_div_zero();
      test_mul_div();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_exec();
      test_err_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
